// File: rtl/j_uart2_txq.sv
// j_uart2_txq: UART2 transmit byte queue and register-access sequencer with fair host sharing.
// Define UART2_TXQ_TIMEOUT_EN to flush the queue and raise stuck after 255 consecutive busy polls.
module j_uart2_txq #(
  parameter int DEPTH    = 8,
  parameter int TBE_BIT  = 7,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        init_req,
  input  logic [15:0] pscl_val,
  input  logic [15:0] ctrl_val,
  output logic        init_done,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic [4:0]  level,
  output logic        ovf,
  input  logic        host_req,
  output logic        host_gnt,
  output logic        u2psclw,
  output logic        u2ctwr,
  output logic        u2strd,
  output logic        u2dwr,
  output logic [15:0] dout,
  input  logic [15:0] stat_in,
  output logic        busy,
  output logic        stuck
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, CFG_P, CFG_C, READY, POLL, WRITE, GAP, HOST} state_t;
  state_t r_state, w_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp, w_lvl;
  logic [3:0] r_gcnt;
  logic [15:0] r_dout;
  logic r_prio, r_pend, r_gnt, r_init_done, r_ovf, r_psclw, r_ctwr, r_strd, r_dwr;
  logic w_init, w_empty, w_full, w_push, w_pop, w_tbe, w_flush, w_eng, w_arb, w_unused;
  assign w_lvl   = r_wp - r_rp;
  assign w_empty = r_wp == r_rp;
  assign w_full  = w_lvl == (AW+1)'(DEPTH);
  assign w_pop   = r_state == WRITE;
  assign w_push  = wr_en && (!w_full || w_pop);
  assign w_tbe   = stat_in[TBE_BIT];
  assign w_init  = init_req || r_pend;
  // r_prio: 0 = engine wins the next contested READY, 1 = host wins
  assign w_eng   = !w_empty && (!host_req || !r_prio);
  assign w_arb   = r_state == READY && !w_init && !w_empty && host_req;
  assign w_unused = ^stat_in;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_init ? CFG_P : host_req ? HOST : IDLE;
      CFG_P:   w_nxt = CFG_C;
      CFG_C:   w_nxt = READY;
      READY:   w_nxt = w_init ? CFG_P : w_eng ? POLL : host_req ? HOST : READY;
      POLL:    w_nxt = w_flush ? READY : w_tbe ? WRITE : GAP;
      WRITE:   w_nxt = GAP;
      GAP:     w_nxt = r_gcnt == 4'd0 ? READY : GAP;
      HOST:    w_nxt = host_req ? HOST : r_init_done ? READY : IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetl) begin
      r_state <= IDLE;
      {r_psclw, r_ctwr, r_strd, r_dwr, r_gnt} <= '0;
      {r_prio, r_pend, r_init_done, r_ovf} <= '0;
      r_dout <= '0;
      r_gcnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_state <= w_nxt;
      r_psclw <= w_nxt == CFG_P;
      r_ctwr <= w_nxt == CFG_C;
      r_strd <= w_nxt == POLL;
      r_dwr <= w_nxt == WRITE;
      r_gnt <= r_state == HOST && host_req;
      r_dout <= w_nxt == CFG_P ? pscl_val : w_nxt == CFG_C ? ctrl_val :
                w_nxt == WRITE ? {8'h00, r_mem[r_rp[AW-1:0]]} : r_dout;
      r_gcnt <= r_state == GAP ? r_gcnt - 4'd1 : 4'(POLL_GAP - 1);
      r_prio <= w_arb ? !r_prio : r_prio;
      r_pend <= w_nxt != CFG_P && (r_pend || init_req && r_state inside {POLL, WRITE, GAP, HOST});
      r_init_done <= r_init_done || r_state == CFG_C;
      r_ovf <= r_state != CFG_C && (r_ovf || wr_en && w_full && !w_pop);
      r_wp <= r_wp + (AW+1)'(w_push);
      r_rp <= w_flush ? r_wp : r_rp + (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= wr_data;
`ifdef UART2_TXQ_TIMEOUT_EN
  logic [7:0] r_tcnt;
  logic r_stuck;
  // the 255th consecutive busy poll gives up on the UART
  assign w_flush = r_state == POLL && !w_tbe && r_tcnt == 8'd254;
  always_ff @(posedge clk) begin
    if (!resetl) begin
      r_tcnt <= '0;
      r_stuck <= 1'b0;
    end else begin
      r_tcnt <= (init_req || r_state == POLL && w_tbe || w_flush) ? 8'd0 :
                r_state == POLL ? r_tcnt + 8'd1 : r_tcnt;
      r_stuck <= r_state != CFG_C && (r_stuck || w_flush);
    end
  end
  assign stuck = r_stuck;
`else
  assign w_flush = 1'b0;
  assign stuck = 1'b0;
`endif
  assign init_done = r_init_done;
  assign full      = w_full;
  assign level     = 5'(w_lvl);
  assign ovf       = r_ovf;
  assign host_gnt  = r_gnt && host_req;
  assign u2psclw   = r_psclw;
  assign u2ctwr    = r_ctwr;
  assign u2strd    = r_strd;
  assign u2dwr     = r_dwr;
  assign dout      = r_dout;
  assign busy      = !(r_state inside {IDLE, READY});
endmodule

// File: tb/tb_j_uart2_txq.sv
// tb_j_uart2_txq: vector tables plus a byte scoreboard for the UART2 transmit queue.
module tb_j_uart2_txq;
  localparam int DEPTH = 8, TBE_BIT = 7, POLL_GAP = 4;
  logic clk = 0, resetl = 0, init_req = 0, wr_en = 0, host_req = 0, tbe = 1;
  logic [15:0] pscl_val = 16'h0040, ctrl_val = 16'h0008, stat_in, dout;
  logic [7:0] wr_data = 0;
  logic init_done, full, ovf, host_gnt, u2psclw, u2ctwr, u2strd, u2dwr, busy, stuck;
  logic [4:0] level;
  int checks = 0, errors = 0, cyc = 0, n;
  logic [7:0] sb[$];
  int strd_cyc[$], dwr_cyc[$];
  logic last_tbe = 0;
  typedef struct { logic init; logic [3:0] stb; logic [15:0] dout; logic done; logic busy; } cfg_t;
  typedef struct { logic wr; logic [7:0] data; logic [4:0] lvl; logic full; logic ovf; } fifo_t;
  cfg_t cfg[4];
  fifo_t ov[10];

  assign stat_in = 16'(tbe) << TBE_BIT;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  j_uart2_txq #(.DEPTH(DEPTH), .TBE_BIT(TBE_BIT), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .resetl(resetl), .init_req(init_req), .pscl_val(pscl_val), .ctrl_val(ctrl_val),
    .init_done(init_done), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .ovf(ovf), .host_req(host_req), .host_gnt(host_gnt), .u2psclw(u2psclw), .u2ctwr(u2ctwr),
    .u2strd(u2strd), .u2dwr(u2dwr), .dout(dout), .stat_in(stat_in), .busy(busy), .stuck(stuck)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_strobes"}, {u2psclw, u2ctwr, u2strd, u2dwr, host_gnt}, 0);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_level"}, level, 0);
    chk({pfx, "_flags"}, {full, ovf, init_done, busy, stuck}, 0);
  endtask

  // scoreboard: bytes accepted by the queue must appear on u2dwr in order, only after a TBE=1 poll
  always @(negedge clk) begin
    if (resetl) begin
      if (u2psclw || u2ctwr || u2strd || u2dwr || host_gnt)
        chk("one_strobe", $countones({u2psclw, u2ctwr, u2strd, u2dwr, host_gnt}), 1);
      if (u2strd) begin
        strd_cyc.push_back(cyc);
        last_tbe = stat_in[TBE_BIT];
      end
      if (u2dwr) begin
        dwr_cyc.push_back(cyc);
        chk("dwr_after_tbe", last_tbe, 1);
        last_tbe = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dwr_unexpected: got %0h expected no write", dout);
        end else chk("dwr_data", dout, {8'h00, sb.pop_front()});
      end
      if (wr_en && sb.size() < DEPTH) sb.push_back(wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg[0] = '{1'b1, 4'b1000, 16'h0040, 1'b0, 1'b1};
    cfg[1] = '{1'b0, 4'b0100, 16'h0008, 1'b0, 1'b1};
    cfg[2] = '{1'b0, 4'b0000, 16'h0008, 1'b1, 1'b0};
    cfg[3] = '{1'b0, 4'b0000, 16'h0008, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++)
      ov[i] = '{i < 9, i == 8 ? 8'hEE : 8'(8'h40 + i), i < 8 ? 5'(i + 1) : 5'd8, i >= 7, i >= 8};

    tick(3);
    check_reset("rst_held");
    resetl = 1;
    tick(2);
    check_reset("rst_idle");

    for (int i = 0; i < 4; i++) begin
      init_req = cfg[i].init;
      tick();
      chk($sformatf("cfg%0d_strobes", i), {u2psclw, u2ctwr, u2strd, u2dwr}, cfg[i].stb);
      chk($sformatf("cfg%0d_dout", i), dout, cfg[i].dout);
      chk($sformatf("cfg%0d_done_busy", i), {init_done, busy}, {cfg[i].done, cfg[i].busy});
    end

    wr_en = 1; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    chk("lat_level1", level, 1);
    tick();
    chk("lat_strd", {u2strd, u2dwr}, 2'b10);
    tick();
    chk("lat_dwr", {u2strd, u2dwr}, 2'b01);
    chk("lat_dout", dout, 16'h00A5);
    chk("lat_level_in_write", level, 1);
    tick();
    chk("lat_level0", level, 0);
    tick(8);

    tbe = 0;
    strd_cyc.delete();
    dwr_cyc.delete();
    foreach (ov[i]) if (i < 3) begin
      wr_en = 1; wr_data = 8'h11 * 8'(i + 1);
      tick();
    end
    wr_en = 0;
    n = 0;
    while (dwr_cyc.size() < 3 && n < 300) begin
      tick();
      tbe = strd_cyc.size() >= 2;
      n++;
    end
    chk("q3_writes", dwr_cyc.size(), 3);
    chk("q3_polls", strd_cyc.size(), 5);
    if (strd_cyc.size() == 5 && dwr_cyc.size() == 3) begin
      for (int i = 0; i < 2; i++) chk("q3_busy_poll_gap", strd_cyc[i+1] - strd_cyc[i], POLL_GAP + 2);
      for (int i = 2; i < 4; i++) chk("q3_write_poll_gap", strd_cyc[i+1] - strd_cyc[i], POLL_GAP + 3);
      for (int i = 0; i < 2; i++) chk("q3_byte_spacing", dwr_cyc[i+1] - dwr_cyc[i], POLL_GAP + 3);
      chk("q3_first_write", dwr_cyc[0] - strd_cyc[2], 1);
    end
    tick(10);

    tbe = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = ov[i].wr; wr_data = ov[i].data;
      tick();
      chk($sformatf("ovf%0d_level", i), level, ov[i].lvl);
      chk($sformatf("ovf%0d_full_ovf", i), {full, ovf}, {ov[i].full, ov[i].ovf});
    end
    wr_en = 0;
    tbe = 1;
    n = 0;
    while (sb.size() > 0 && n < 200) begin tick(); n++; end
    chk("ovf_drained", sb.size(), 0);
    tick(20);
    chk("ovf_empty_after_drain", {level, full}, 0);
    chk("ovf_sticky", ovf, 1);

    wr_en = 1; wr_data = 8'hC1;
    tick();
    wr_data = 8'hC2; host_req = 1;
    tick();
    wr_en = 0;
    chk("arb_engine_first", {u2strd, host_gnt}, 2'b10);
    n = 0;
    while (!host_gnt && n < 50) begin tick(); n++; end
    chk("arb_host_second", n, POLL_GAP + 4);
    init_req = 1;
    tick();
    init_req = 0;
    chk("host_hold", host_gnt, 1);
    tick(2);
    chk("host_hold_busy", {host_gnt, busy}, 2'b11);
    host_req = 0;
    #1;
    chk("host_drop_same_cycle", host_gnt, 0);
    tick(2);
    chk("init_latched", {u2psclw, dout}, {1'b1, 16'h0040});
    tick(2);
    chk("reinit_clears_ovf", {ovf, init_done}, 2'b01);
    n = 0;
    while (sb.size() > 0 && n < 50) begin tick(); n++; end
    chk("arb_engine_after_host", sb.size(), 0);
    tick(10);

    tbe = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'hD0 + 8'(i);
      tick();
    end
    wr_en = 0;
    tick(3);
    tbe = 1;
    n = 0;
    while (!u2dwr && n < 50) begin tick(); n++; end
    chk("rstw_in_write", {u2dwr, level}, {1'b1, 5'd4});
    resetl = 0;
    tick();
    check_reset("rstw_next");
    resetl = 1;
    sb.delete();
    tick(5);
    check_reset("rstw_after");

`ifdef UART2_TXQ_TIMEOUT_EN
    init_req = 1;
    tick();
    init_req = 0;
    tick(3);
    tbe = 0;
    strd_cyc.delete();
    wr_en = 1; wr_data = 8'h5A;
    tick();
    wr_en = 0;
    n = 0;
    while (!stuck && n < 2000) begin tick(); n++; end
    chk("to_stuck", stuck, 1);
    chk("to_flushed", level, 0);
    chk("to_poll_count", strd_cyc.size(), 255);
    sb.delete();
    tick(10);
    chk("to_no_more_polls", strd_cyc.size(), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
